uart_pkt_decoder: RTL and testbench

Framed-packet decoder directly downstream of the UART receiver. Consumes the receiver's one-cycle byte strobes, finds start-of-frame, collects length-prefixed payloads and checks an XOR checksum. Good payloads are replayed on a valid/ready byte stream with a last marker. Bad frames are dropped and flagged.

---
 rtl/uart_pkt_decoder_if.sv | 21 ++
 rtl/uart_pkt_decoder.sv | 181 ++++++++++++++++++
 tb/tb_uart_pkt_decoder.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_decoder_if.sv
// Byte-stream bundle around the packet decoder: receiver strobes in, valid/ready payload out.
// slave is the decoder side; master is the receiver/sink side.
interface uart_pkt_decoder_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_break;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    modport master (
        output in_valid, in_data, in_break, out_ready,
        input  out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_break, out_ready,
        output out_valid, out_data, out_last
    );
endinterface

// File: rtl/uart_pkt_decoder.sv
// Framed-packet decoder: SOF, LEN, payload, XOR checksum. Good payloads are replayed on a
// valid/ready stream with a last marker; bad frames are dropped and flagged with one-cycle pulses.
module uart_pkt_decoder #(
    parameter logic [7:0]  SOF_BYTE       = 8'hA5,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    uart_pkt_decoder_if.slave bus_io,
    output logic              pkt_ok,
    output logic              err_chk,
    output logic              err_len,
    output logic              err_timeout,
    output logic              err_overrun,
    output logic              busy
);
    localparam int unsigned     IdxW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned     CntW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]      MaxLen  = 8'(MAX_LEN);
    localparam logic [CntW-1:0] TmoLast = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [IdxW-1:0] Idx0    = '0;

    typedef enum logic [2:0] {StIdle, StLen, StPayload, StChk, StDrain} state_e;

    state_e          state_q;
    logic [7:0]      len_q, idx_q, rd_q, xor_q;
    logic [CntW-1:0] tmo_q;
    logic [7:0]      out_data_q;
    logic            out_valid_q, out_last_q, busy_q;
    logic            pkt_ok_q, err_chk_q, err_len_q, err_timeout_q, err_overrun_q;
    logic [7:0]      buf_q [MAX_LEN];

    logic       byte_v, brk_v, in_frame, tmo_hit;
    logic [7:0] rd_inc;

    assign byte_v   = bus_io.in_valid && !bus_io.in_break;
    assign brk_v    = bus_io.in_valid && bus_io.in_break;
    assign in_frame = (state_q == StLen) || (state_q == StPayload) || (state_q == StChk);
    assign tmo_hit  = !bus_io.in_valid && (tmo_q == TmoLast);
    assign rd_inc   = rd_q + 8'd1;

    // Payload storage has no reset; only the first len entries are ever read back.
    always_ff @(posedge clk) begin
        if (state_q == StPayload && byte_v) begin
            buf_q[idx_q[IdxW-1:0]] <= bus_io.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            len_q         <= '0;
            idx_q         <= '0;
            rd_q          <= '0;
            xor_q         <= '0;
            tmo_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            busy_q        <= 1'b0;
            pkt_ok_q      <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            pkt_ok_q      <= 1'b0;
            err_chk_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;

            if (in_frame) begin
                tmo_q <= bus_io.in_valid ? '0 : tmo_q + 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (byte_v && bus_io.in_data == SOF_BYTE) begin
                        state_q <= StLen;
                        busy_q  <= 1'b1;
                        tmo_q   <= '0;
                    end
                end
                StLen: begin
                    if (brk_v) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (byte_v) begin
                        len_q <= bus_io.in_data;
                        xor_q <= bus_io.in_data;
                        if (bus_io.in_data == 8'd0 || bus_io.in_data > MaxLen) begin
                            err_len_q <= 1'b1;
                            state_q   <= StIdle;
                            busy_q    <= 1'b0;
                        end else begin
                            idx_q   <= '0;
                            state_q <= StPayload;
                        end
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= StIdle;
                        busy_q        <= 1'b0;
                    end
                end
                StPayload: begin
                    if (brk_v) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (byte_v) begin
                        xor_q <= xor_q ^ bus_io.in_data;
                        idx_q <= idx_q + 8'd1;
                        if (idx_q == len_q - 8'd1) begin
                            state_q <= StChk;
                        end
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= StIdle;
                        busy_q        <= 1'b0;
                    end
                end
                StChk: begin
                    if (brk_v) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (byte_v) begin
                        if (bus_io.in_data == xor_q) begin
                            // First payload byte is presented in the same cycle as pkt_ok.
                            pkt_ok_q    <= 1'b1;
                            rd_q        <= '0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= buf_q[Idx0];
                            out_last_q  <= (len_q == 8'd1);
                            state_q     <= StDrain;
                        end else begin
                            err_chk_q <= 1'b1;
                            state_q   <= StIdle;
                            busy_q    <= 1'b0;
                        end
                    end else if (tmo_hit) begin
                        err_timeout_q <= 1'b1;
                        state_q       <= StIdle;
                        busy_q        <= 1'b0;
                    end
                end
                StDrain: begin
                    if (bus_io.in_valid) begin
                        err_overrun_q <= 1'b1;
                    end
                    if (out_valid_q && bus_io.out_ready) begin
                        if (rd_q == len_q - 8'd1) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= StIdle;
                            busy_q      <= 1'b0;
                        end else begin
                            rd_q       <= rd_inc;
                            out_data_q <= buf_q[rd_inc[IdxW-1:0]];
                            out_last_q <= (rd_inc == len_q - 8'd1);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_io.out_valid = out_valid_q;
    assign bus_io.out_data  = out_data_q;
    assign bus_io.out_last  = out_last_q;
    assign pkt_ok           = pkt_ok_q;
    assign err_chk          = err_chk_q;
    assign err_len          = err_len_q;
    assign err_timeout      = err_timeout_q;
    assign err_overrun      = err_overrun_q;
    assign busy             = busy_q;
endmodule

// File: tb/tb_uart_pkt_decoder.sv
// Directed bench for uart_pkt_decoder: scoreboard of expected payload bytes and pulse counts.
module tb_uart_pkt_decoder;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_pkt_decoder_if bus ();
    logic pkt_ok, err_chk, err_len, err_timeout, err_overrun, busy;

    uart_pkt_decoder #(
        .SOF_BYTE      (8'hA5),
        .MAX_LEN       (16),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_io     (bus),
        .pkt_ok     (pkt_ok),
        .err_chk    (err_chk),
        .err_len    (err_len),
        .err_timeout(err_timeout),
        .err_overrun(err_overrun),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int n_ok = 0, n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;
    int e_ok = 0, e_chk = 0, e_len = 0, e_tmo = 0, e_ovr = 0;
    logic [8:0] sb [$];
    logic [7:0] pl [$];
    logic       stall = 1'b0;
    logic [8:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input logic brk);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_break = brk;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_break = 1'b0;
    endtask

    // Sends SOF, LEN, pl, then LEN^payload^flip; flip==0 means a good frame.
    task automatic send_frame(input logic [7:0] flip);
        logic [7:0] x;
        x = 8'(pl.size());
        send(8'hA5, 1'b0);
        send(x, 1'b0);
        foreach (pl[i]) begin
            if (flip == 8'h00) sb.push_back({(i == pl.size() - 1), pl[i]});
            send(pl[i], 1'b0);
            x ^= pl[i];
        end
        send(x ^ flip, 1'b0);
        if (flip == 8'h00) e_ok++;
        else e_chk++;
    endtask

    task automatic chk_pulses(input string tag);
        chk({tag, "/pkt_ok"}, n_ok, e_ok);
        chk({tag, "/err_chk"}, n_chk, e_chk);
        chk({tag, "/err_len"}, n_len, e_len);
        chk({tag, "/err_timeout"}, n_tmo, e_tmo);
        chk({tag, "/err_overrun"}, n_ovr, e_ovr);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 300) begin
            tick(1);
            n++;
        end
        chk({tag, "/drain_done"}, 32'(n < 300), 32'd1);
    endtask

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("stall_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_hold", 32'({bus.out_last, bus.out_data}), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("out_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    chk("out_byte", 32'({bus.out_last, bus.out_data}), 32'(sb.pop_front()));
                end
            end
            if (pkt_ok) chk("ok_with_valid", 32'(bus.out_valid), 32'd1);
            n_ok  += int'(pkt_ok);
            n_chk += int'(err_chk);
            n_len += int'(err_len);
            n_tmo += int'(err_timeout);
            n_ovr += int'(err_overrun);
            stall = bus.out_valid && !bus.out_ready;
            held  = {bus.out_last, bus.out_data};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_break  = 1'b0;
        bus.out_ready = 1'b1;
        tick(3);
        chk("reset_outs", 32'({bus.out_valid, bus.out_last, bus.out_data, busy, pkt_ok, err_chk,
                              err_len, err_timeout, err_overrun}), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("reset_idle", 32'(busy), 32'd0);

        // Good frame, back-to-back delivery.
        pl = '{8'h11, 8'h22, 8'h33};
        send_frame(8'h00);
        chk("good_first", 32'({pkt_ok, bus.out_valid, bus.out_data}), 32'h311);
        tick(1);
        chk("good_b2b1", 32'(bus.out_valid), 32'd1);
        tick(1);
        chk("good_b2b2", 32'({bus.out_valid, bus.out_last}), 32'd3);
        tick(1);
        chk("good_end", 32'({bus.out_valid, busy}), 32'd0);
        wait_idle("good");
        chk_pulses("good");

        // Bad checksum (0x32 expected, 0x00 sent), then a good frame.
        pl = '{8'h10, 8'h20};
        send_frame(8'h32);
        tick(3);
        chk("badchk_noout", 32'({bus.out_valid, busy}), 32'd0);
        chk_pulses("badchk");
        pl = '{8'h5A, 8'hC3};
        send_frame(8'h00);
        wait_idle("after_bad");
        chk_pulses("after_bad");

        // Noise and length errors.
        send(8'h55, 1'b0);
        send(8'hFF, 1'b0);
        tick(2);
        chk("noise_idle", 32'(busy), 32'd0);
        chk_pulses("noise");
        send(8'hA5, 1'b0);
        send(8'h00, 1'b0);
        e_len++;
        tick(2);
        chk_pulses("len0");
        send(8'hA5, 1'b0);
        send(8'h11, 1'b0);
        e_len++;
        tick(2);
        chk("len17_idle", 32'(busy), 32'd0);
        chk_pulses("len17");

        // Maximum-length frame.
        pl.delete();
        for (int i = 0; i < 16; i++) pl.push_back(8'(i * 7 + 1));
        send_frame(8'h00);
        wait_idle("maxlen");
        chk_pulses("maxlen");

        // Back-pressure: ready 1,0,1 then 5 low, then 1,0,1.
        bus.out_ready = 1'b0;
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(8'h00);
        for (int i = 0; i < 16; i++) begin
            logic [15:0] pat;
            pat = 16'h0505;
            bus.out_ready = pat[i];
            tick(1);
        end
        bus.out_ready = 1'b1;
        wait_idle("bp");
        chk_pulses("bp");

        // Inter-byte timeout.
        send(8'hA5, 1'b0);
        send(8'h02, 1'b0);
        send(8'hAA, 1'b0);
        e_tmo++;
        n = 0;
        while (!err_timeout && n < 40) begin
            tick(1);
            n++;
        end
        chk("tmo_latency", n, 20);
        chk("tmo_busy", 32'(busy), 32'd0);
        tick(2);
        chk_pulses("tmo");

        // Break during payload aborts silently.
        send(8'hA5, 1'b0);
        send(8'h03, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        tick(2);
        chk("brk_idle", 32'(busy), 32'd0);
        chk_pulses("brk");

        // Reset mid-payload.
        send(8'hA5, 1'b0);
        send(8'h04, 1'b0);
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        chk("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick(1);
        chk("reset_mid_outs", 32'({bus.out_valid, bus.out_last, bus.out_data, busy, pkt_ok,
                                  err_chk, err_len, err_timeout, err_overrun}), 32'd0);
        reset = 1'b0;
        tick(1);
        chk("reset_mid_idle", 32'(busy), 32'd0);
        chk_pulses("reset_mid");

        // Overrun during stalled drain.
        bus.out_ready = 1'b0;
        pl = '{8'h31, 8'h32, 8'h33};
        send_frame(8'h00);
        send(8'h12, 1'b0);
        send(8'hA5, 1'b1);
        e_ovr += 2;
        tick(1);
        chk_pulses("ovr");
        chk("ovr_still_busy", 32'({busy, bus.out_valid, bus.out_data}), 32'h331);
        bus.out_ready = 1'b1;
        wait_idle("ovr_drain");
        chk_pulses("ovr_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
